// File: rtl/video_pkg.sv
// video_pkg: shared timing types, 720p60 constants and blanking/total helpers.
package video_pkg;

  typedef struct packed {
    int unsigned front;
    int unsigned sync;
    int unsigned back;
    int unsigned active;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } video_timing_t;

  localparam video_timing_t TIMING_720P60 = '{
    h: '{front: 110, sync: 40, back: 220, active: 1280},
    v: '{front: 5, sync: 5, back: 20, active: 720}
  };

  function automatic int unsigned blank(axis_timing_t t);
    return t.front + t.sync + t.back;
  endfunction

  function automatic int unsigned total(axis_timing_t t);
    return blank(t) + t.active;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter: one timing axis (porch/sync/porch/active) with wrap strobe.
module video_axis_counter #(
  parameter int W     = 13,
  parameter int FRONT = 110,
  parameter int SYNC  = 40,
  parameter int BLANK = 370,
  parameter int TOTAL = 1650
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync,
  output logic         active
);

  assign wrap    = adv && cnt == W'(TOTAL - 1);
  assign in_sync = cnt >= W'(FRONT) && cnt < W'(FRONT + SYNC);
  assign active  = cnt >= W'(BLANK);

  always_ff @(posedge clk)
    cnt <= (reset || wrap) ? '0 : adv ? cnt + W'(1) : cnt;

endmodule

// File: rtl/video_timing_tx.sv
// video_timing_tx: programmable H/V video timing engine pulling pixels from a valid/ready stream.
// Define VIDEO_TX_TEST_PATTERN_EN to show colour bars instead of black while no source is locked.
module video_timing_tx
  import video_pkg::*;
#(
  parameter int COLOR_WIDTH = 8,
  parameter int HFRONT      = int'(TIMING_720P60.h.front),
  parameter int HSYNC       = int'(TIMING_720P60.h.sync),
  parameter int HBACK       = int'(TIMING_720P60.h.back),
  parameter int HACTIVE     = int'(TIMING_720P60.h.active),
  parameter int VFRONT      = int'(TIMING_720P60.v.front),
  parameter int VSYNC       = int'(TIMING_720P60.v.sync),
  parameter int VBACK       = int'(TIMING_720P60.v.back),
  parameter int VACTIVE     = int'(TIMING_720P60.v.active),
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LREQ_LEAD   = 10,
  parameter int CNT_WIDTH   = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_i,
  input  logic                     pix_valid_i,
  input  logic [3*COLOR_WIDTH-1:0] pix_data_i,
  output logic                     pix_ready_o,
  output logic                     line_request_o,
  output logic                     sof_o,
  output logic                     data_enable,
  output logic                     hsync,
  output logic                     vsync,
  output logic [COLOR_WIDTH-1:0]   data_r,
  output logic [COLOR_WIDTH-1:0]   data_g,
  output logic [COLOR_WIDTH-1:0]   data_b,
  output logic                     underflow_o
);

  localparam axis_timing_t HT = '{HFRONT, HSYNC, HBACK, HACTIVE};
  localparam axis_timing_t VT = '{VFRONT, VSYNC, VBACK, VACTIVE};
  localparam int HBLANK = int'(blank(HT));
  localparam int HTOTAL = int'(total(HT));
  localparam int VBLANK = int'(blank(VT));
  localparam int VTOTAL = int'(total(VT));

  typedef struct packed {
    logic [COLOR_WIDTH-1:0] b;
    logic [COLOR_WIDTH-1:0] g;
    logic [COLOR_WIDTH-1:0] r;
  } rgb_t;

  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic lock, origin, active_c, lreq_c;
  rgb_t bar_c, nxt, pix_q;

  video_axis_counter #(
    .W(CNT_WIDTH), .FRONT(HFRONT), .SYNC(HSYNC), .BLANK(HBLANK), .TOTAL(HTOTAL)
  ) h_axis (
    .clk, .reset, .adv(1'b1), .cnt(h_cnt), .wrap(h_wrap), .in_sync(h_sync), .active(h_act)
  );

  video_axis_counter #(
    .W(CNT_WIDTH), .FRONT(VFRONT), .SYNC(VSYNC), .BLANK(VBLANK), .TOTAL(VTOTAL)
  ) v_axis (
    .clk, .reset, .adv(h_wrap), .cnt(v_cnt), .wrap(v_wrap), .in_sync(v_sync), .active(v_act)
  );

  assign active_c    = h_act && v_act;
  assign pix_ready_o = active_c && lock;
  assign lreq_c      = lock && h_cnt == CNT_WIDTH'(HBLANK - LREQ_LEAD) &&
                       v_cnt >= CNT_WIDTH'(VBLANK - 1) && v_cnt <= CNT_WIDTH'(VTOTAL - 2);

`ifdef VIDEO_TX_TEST_PATTERN_EN
  localparam logic [COLOR_WIDTH-1:0] FS = '1;
  localparam logic [COLOR_WIDTH-1:0] ZR = '0;
  logic [CNT_WIDTH-1:0] hx;
  assign hx    = h_cnt - CNT_WIDTH'(HBLANK);
  assign bar_c = hx < CNT_WIDTH'(HACTIVE / 4)     ? rgb_t'{b: ZR, g: ZR, r: FS} :
                 hx < CNT_WIDTH'(HACTIVE / 2)     ? rgb_t'{b: ZR, g: FS, r: ZR} :
                 hx < CNT_WIDTH'(3 * HACTIVE / 4) ? rgb_t'{b: FS, g: ZR, r: ZR} :
                                                    rgb_t'{b: FS, g: FS, r: FS};
`else
  assign bar_c = '0;
`endif

  always_comb begin
    nxt = '0;
    if (active_c) nxt = lock ? (pix_valid_i ? rgb_t'(pix_data_i) : rgb_t'('0)) : bar_c;
  end

  // origin marks the cycle in which both counters sit at 0 (after reset or a frame wrap)
  always_ff @(posedge clk) begin
    if (reset) begin
      origin         <= 1'b1;
      lock           <= 1'b0;
      sof_o          <= 1'b0;
      line_request_o <= 1'b0;
      underflow_o    <= 1'b0;
      data_enable    <= 1'b0;
      hsync          <= ~HS_POL;
      vsync          <= ~VS_POL;
      pix_q          <= '0;
    end else begin
      origin         <= v_wrap;
      lock           <= origin ? enable_i : lock;
      sof_o          <= origin;
      line_request_o <= lreq_c;
      underflow_o    <= !origin && (underflow_o || (pix_ready_o && !pix_valid_i));
      data_enable    <= active_c;
      hsync          <= h_sync ? HS_POL : ~HS_POL;
      vsync          <= v_sync ? VS_POL : ~VS_POL;
      pix_q          <= nxt;
    end
  end

  assign data_r = pix_q.r;
  assign data_g = pix_q.g;
  assign data_b = pix_q.b;

endmodule

// File: tb/tb_video_timing_tx.sv
// tb_video_timing_tx: scoreboard bench on a 14x7 timing with a cycle-level reference model.
module tb_video_timing_tx;

  localparam int HT = 14, VT = 7, HB = 6, VB = 3;

  logic clk = 1'b0;
  logic reset, enable_i, pix_valid_i, pix_ready_o, line_request_o, sof_o;
  logic data_enable, hsync, vsync, underflow_o;
  logic [23:0] pix_data_i;
  logic [7:0] data_r, data_g, data_b;

  int checks = 0, failures = 0;
  int mh, mv;
  bit mlock, muf, counting;
  int n_de, n_lreq, n_vs, n_hs;
  logic [23:0] ramp = '0;

  typedef struct packed {
    logic de, hs, vs, sof, lreq, uf;
    logic [23:0] rgb;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  video_timing_tx #(
    .COLOR_WIDTH(8), .HFRONT(2), .HSYNC(2), .HBACK(2), .HACTIVE(8),
    .VFRONT(1), .VSYNC(1), .VBACK(1), .VACTIVE(4),
    .HS_POL(1'b0), .VS_POL(1'b0), .LREQ_LEAD(1), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .pix_valid_i(pix_valid_i),
    .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o), .line_request_o(line_request_o),
    .sof_o(sof_o), .data_enable(data_enable), .hsync(hsync), .vsync(vsync),
    .data_r(data_r), .data_g(data_g), .data_b(data_b), .underflow_o(underflow_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (h=%0d v=%0d)", tag, got, want, mh, mv);
    end
  endtask

  function automatic logic [23:0] pattern(input int x);
`ifdef VIDEO_TX_TEST_PATTERN_EN
    case (x / 2)
      0:       return 24'h0000FF;
      1:       return 24'h00FF00;
      2:       return 24'hFF0000;
      default: return 24'hFFFFFF;
    endcase
`else
    return 24'h0;
`endif
  endfunction

  task automatic step(input bit rst, input bit en, input bit val);
    exp_t e, o;
    bit act, fs;
    @(negedge clk);
    reset = rst; enable_i = en; pix_valid_i = val;
    ramp = ramp + 24'h010203;
    pix_data_i = ramp;
    #1;
    act = mh >= HB && mv >= VB;
    fs  = mh == 0 && mv == 0;
    check("pix_ready", pix_ready_o, act && mlock);
    if (rst) e = '{de: 0, hs: 1, vs: 1, sof: 0, lreq: 0, uf: 0, rgb: 0};
    else begin
      e.de   = act;
      e.hs   = !(mh >= 2 && mh < 4);
      e.vs   = mv != 1;
      e.sof  = fs;
      e.lreq = mlock && mh == HB - 1 && mv >= VB - 1 && mv <= VT - 2;
      e.uf   = !fs && (muf || (act && mlock && !val));
      e.rgb  = !act ? 24'h0 : mlock ? (val ? ramp : 24'h0) : pattern(mh - HB);
    end
    sb.push_back(e);
    muf = e.uf;
    if (rst) begin
      mh = 0; mv = 0; mlock = 0;
    end else begin
      if (fs) mlock = en;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
    end
    @(posedge clk);
    #1;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      o = sb.pop_front();
      check("data_enable", data_enable, o.de);
      check("hsync", hsync, o.hs);
      check("vsync", vsync, o.vs);
      check("sof", sof_o, o.sof);
      check("line_request", line_request_o, o.lreq);
      check("underflow", underflow_o, o.uf);
      check("rgb", {data_b, data_g, data_r}, o.rgb);
    end
    if (counting) begin
      n_de += int'(data_enable);
      n_lreq += int'(line_request_o);
      n_vs += int'(!vsync);
      n_hs += int'(!hsync);
    end
  endtask

  initial begin
    reset = 1'b1; enable_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = '0;
    repeat (2) @(posedge clk);
    mh = 0; mv = 0; mlock = 0; muf = 0;
    counting = 0; n_de = 0; n_lreq = 0; n_vs = 0; n_hs = 0;

    // locked ramp, one full frame counted
    counting = 1;
    repeat (HT * VT) step(0, 1, 1);
    counting = 0;
    check("de_per_frame", n_de, 32);
    check("lreq_per_frame", n_lreq, 4);
    check("vsync_low_cycles", n_vs, 14);
    check("hsync_low_cycles", n_hs, 14);

    // single dropped pixel mid-frame, then one at the last pixel of the frame
    for (int i = 0; i < 3 * HT * VT; i++)
      step(0, 1, !((mh == 8 && mv == 4) || (i >= HT * VT && mh == HT - 1 && mv == VT - 1)));

    // enable raised mid-frame: nothing pulled until the next frame start
    step(1, 0, 0);
    for (int i = 0; i < 3 * HT * VT; i++) step(0, i >= 40, 1);

    // reset at h=9, v=5 with a locked source
    for (int i = 0; i < 2 * HT * VT && !(mh == 9 && mv == 5); i++) step(0, 1, 1);
    check("reached_h9_v5", {mh[15:0], mv[15:0]}, {16'd9, 16'd5});
    step(1, 1, 1);
    repeat (HT * VT + 4) step(0, 1, 1);

    // unlocked frame: black, or colour bars when the pattern is built in
    step(1, 0, 0);
    repeat (2 * HT * VT) step(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
